irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of external interrupt channels (1..32).
REQ-002 Parameter VEC_BASE, default 32'h0000_0100, handler address of channel 0.
REQ-003 Parameter VEC_STRIDE, default 4, address spacing between channel handlers.
REQ-004 Parameter EDGE_MASK, default all ones (NUM_IRQ bits); bit i = 1 makes channel i edge-triggered, 0 makes it level-triggered.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 irq_in  in  NUM_IRQ  raw external interrupt lines.
REQ-008 global_en  in  1  master interrupt enable.
REQ-009 en_we  in  1  write strobe for channel-enable register.
REQ-010 en_wdata  in  NUM_IRQ  new channel-enable value.
REQ-011 take_ack  in  1  pipeline accepted the redirect to the handler.
REQ-012 mret  in  1  handler returned.
REQ-013 interrupt_ctrl  out  1  redirect request to fetch.
REQ-014 interrupt_handling_addr  out  32  handler address for the requested or active channel.
REQ-015 active_id  out  $clog2(NUM_IRQ) (min 1)  channel being requested or serviced.
REQ-016 in_service  out  1  handler running.
REQ-017 pending  out  NUM_IRQ  pending vector.

Function
REQ-018 irq_in registered into irq_s each cycle; irq_s registered into irq_d.
- Edge channel i: pending[i] set when irq_s[i] & ~irq_d[i].
- Level channel i: pending[i] = irq_s[i] each cycle.
REQ-019 Edge pending bit clears only on take_ack for that channel. An edge detected in the same cycle as the clear wins, and the bit stays set.
REQ-020 enable register resets to all zeros. It is written from en_wdata on en_we. Disabled channels still accumulate pending.
REQ-021 Eligible vector = pending & enable & {global_en}. Lowest index has highest priority.
REQ-022 FSM states IDLE, REQ, ACTIVE.
- IDLE -> REQ when the eligible vector is nonzero. active_id latches the winning index at that edge.
- REQ -> ACTIVE on take_ack.
- REQ -> IDLE when the latched channel is no longer eligible and take_ack is low. If both occur in the same cycle, take_ack wins.
- ACTIVE -> IDLE on mret.
REQ-023 Outputs per state:
- interrupt_ctrl = 1 only in REQ.
- in_service = 1 only in ACTIVE.
- active_id is held through REQ and ACTIVE.
REQ-024 interrupt_handling_addr = VEC_BASE + active_id*VEC_STRIDE, computed 32-bit with wrap-around. It is stable throughout REQ and ACTIVE.
REQ-025 No preemption in REQ or ACTIVE. A higher-priority arrival remains pending and is taken after return to IDLE.
REQ-026 Latency for an edge channel:
- irq_in high sampled at edge E0.
- pending set after E1.
- interrupt_ctrl high after E2.
REQ-027 Return to a new request:
- mret at edge E -> IDLE after E.
- Next REQ possible after E+1, so there is at least one IDLE cycle between handlers.
REQ-028 Ignored inputs:
- take_ack ignored in IDLE and ACTIVE.
- mret ignored in IDLE and REQ.

Reset
REQ-029 While rst is high at a clock edge, all of the following take these values, overriding all other inputs:
- state IDLE.
- interrupt_ctrl 0, in_service 0.
- active_id 0, interrupt_handling_addr VEC_BASE.
- pending 0, enable 0, irq_s 0, irq_d 0.
REQ-030 Reset asserted mid-REQ or mid-ACTIVE discards the request or service. No pending bit survives reset.

Verification (NUM_IRQ=8, VEC_BASE=0x100, VEC_STRIDE=4, EDGE_MASK=8'hF0)
REQ-031 Single level channel:
- Stimulus: enable=8'hFF, global_en=1, irq_in[2] pulses high.
- Response: interrupt_ctrl=1 two cycles later, addr=0x108, active_id=2.
- take_ack -> in_service=1.
- mret -> IDLE.
REQ-032 Priority:
- Stimulus: irq_in[5] and irq_in[3] rise in the same cycle.
- Response: channel 3 is requested first (addr 0x10C).
- After ack, mret and one IDLE cycle, channel 5 is requested (addr 0x114).
REQ-033 Edge re-pend:
- Stimulus: second rising edge on irq_in[4] in the exact cycle take_ack clears channel 4.
- Response: pending[4] stays 1, and channel 4 is requested again after mret.
REQ-034 Withdraw:
- Stimulus: in REQ for channel 6, en_we writes 8'h00 with take_ack=0.
- Response: next cycle IDLE, interrupt_ctrl=0, pending[6] still 1.
- Re-enabling channel 6 produces REQ again.
REQ-035 Masking:
- Stimulus: global_en=0 with pending=8'hFF.
- Response: no REQ.
- Raising global_en -> REQ for channel 0, addr 0x100.
REQ-036 Reset mid-service:
- Stimulus: rst=1 during ACTIVE for channel 7.
- Response: after the edge, in_service=0, active_id=0, addr=0x100, pending=0, enable=0.

Source files
------------

// File: rtl/irq_controller.sv
// Vectored interrupt controller: synchronises raw lines, tracks edge/level
// pending state, and hands one fixed-priority request at a time to fetch.
module irq_controller #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1,
    localparam int         IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               global_en,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    input  logic               take_ack,
    input  logic               mret,
    output logic               interrupt_ctrl,
    output logic [31:0]        interrupt_handling_addr,
    output logic [IDW-1:0]     active_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

    localparam logic [31:0] STRIDE32 = 32'(VEC_STRIDE);

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] irq_s, irq_d;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] pend_r, pend_nxt;
    logic [NUM_IRQ-1:0] edge_det, clr, eligible;
    logic [IDW-1:0]     id_r;
    logic               take_fire;

    function automatic logic [IDW-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDW'(i);
        end
    endfunction

    // Stage: two-flop capture of the raw lines
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s <= '0;
            irq_d <= '0;
        end else begin
            irq_s <= irq_in;
            irq_d <= irq_s;
        end
    end

    // Stage: pending tracking; a fresh edge outranks the acknowledge clear
    always_comb begin
        take_fire = (state == REQ) && take_ack;
        edge_det  = irq_s & ~irq_d;
        clr       = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = take_fire && (id_r == IDW'(i));
        end
        pend_nxt = (EDGE_MASK & ((pend_r & ~clr) | edge_det)) | (~EDGE_MASK & irq_s);
        eligible = pend_r & enable & {NUM_IRQ{global_en}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= '0;
            enable <= '0;
        end else begin
            pend_r <= pend_nxt;
            if (en_we) enable <= en_wdata;
        end
    end

    // Stage: request/service sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            id_r  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |eligible) id_r <= lowest_idx(eligible);
        end
    end

    always_comb begin
        state_nxt      = state;
        interrupt_ctrl = 1'b0;
        in_service     = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) state_nxt = REQ;
            end
            REQ: begin
                interrupt_ctrl = 1'b1;
                if (take_ack)            state_nxt = ACTIVE;
                else if (!eligible[id_r]) state_nxt = IDLE;
            end
            ACTIVE: begin
                in_service = 1'b1;
                if (mret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active_id               = id_r;
    assign pending                 = pend_r;
    assign interrupt_handling_addr = VEC_BASE + (32'(id_r) * STRIDE32);

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expected requests are queued as stimulus
// is applied and checked when interrupt_ctrl rises.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst, global_en, en_we, take_ack, mret;
    logic [7:0]  irq_in, en_wdata, pending;
    logic        interrupt_ctrl, in_service;
    logic [31:0] interrupt_handling_addr;
    logic [2:0]  active_id;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_IRQ(8), .VEC_BASE(32'h100), .VEC_STRIDE(4), .EDGE_MASK(8'hF0)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .global_en(global_en),
        .en_we(en_we), .en_wdata(en_wdata), .take_ack(take_ack), .mret(mret),
        .interrupt_ctrl(interrupt_ctrl),
        .interrupt_handling_addr(interrupt_handling_addr),
        .active_id(active_id), .in_service(in_service), .pending(pending)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for interrupt_ctrl; lat = negedges waited, -1 on timeout.
    task automatic wait_req(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (interrupt_ctrl === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; global_en = 1'b0; en_we = 1'b0; en_wdata = '0;
        take_ack = 1'b0; mret = 1'b0; irq_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({interrupt_ctrl, in_service} !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl got %b want 00", {interrupt_ctrl, in_service});
        end
        checks++;
        if (active_id !== 3'd0 || interrupt_handling_addr !== 32'h100) begin
            errors++; $display("FAIL reset_id got %0d/%h want 0/100", active_id, interrupt_handling_addr);
        end
        checks++;
        if (pending !== 8'h00) begin
            errors++; $display("FAIL reset_pending got %h want 00", pending);
        end
    endtask

    task automatic test_level();
        int   lat;
        exp_t e;
        en_we = 1'b1; en_wdata = 8'hFF; global_en = 1'b1;
        @(negedge clk);
        en_we = 1'b0;
        irq_in[2] = 1'b1;
        exp_q.push_back('{id: 3'd2, addr: 32'h108});
        wait_req(lat);
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL level_latency got %0d want 3", lat);
        end
        checks++;
        e = exp_q.pop_front();
        if ({active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL level_req got %0d/%h want %0d/%h", active_id, interrupt_handling_addr, e.id, e.addr);
        end
        take_ack = 1'b1; irq_in[2] = 1'b0;
        @(negedge clk);
        take_ack = 1'b0;
        checks++;
        if ({interrupt_ctrl, in_service} !== 2'b01) begin
            errors++; $display("FAIL level_active got %b want 01", {interrupt_ctrl, in_service});
        end
        idle_cycles(2);
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        checks++;
        if ({interrupt_ctrl, in_service} !== 2'b00) begin
            errors++; $display("FAIL level_mret got %b want 00", {interrupt_ctrl, in_service});
        end
        idle_cycles(3);
        checks++;
        if (interrupt_ctrl !== 1'b0) begin
            errors++; $display("FAIL level_quiet got %b want 0", interrupt_ctrl);
        end
    endtask

    task automatic test_priority();
        int   lat;
        exp_t e;
        irq_in[5] = 1'b1; irq_in[3] = 1'b1;
        exp_q.push_back('{id: 3'd3, addr: 32'h10C});
        exp_q.push_back('{id: 3'd5, addr: 32'h114});
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat < 0 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL prio_first got %0d/%h want %0d/%h (lat %0d)", active_id, interrupt_handling_addr, e.id, e.addr, lat);
        end
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        checks++;
        if ({interrupt_ctrl, in_service} !== 2'b10) begin
            errors++; $display("FAIL prio_mret_in_req got %b want 10", {interrupt_ctrl, in_service});
        end
        take_ack = 1'b1; irq_in[3] = 1'b0;
        @(negedge clk);
        take_ack = 1'b0;
        idle_cycles(3);
        checks++;
        if ({interrupt_ctrl, in_service, pending[5]} !== 3'b011) begin
            errors++; $display("FAIL prio_no_preempt got %b want 011", {interrupt_ctrl, in_service, pending[5]});
        end
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        checks++;
        if ({interrupt_ctrl, in_service} !== 2'b00) begin
            errors++; $display("FAIL prio_idle_gap got %b want 00", {interrupt_ctrl, in_service});
        end
        @(negedge clk);
        checks++;
        e = exp_q.pop_front();
        if (interrupt_ctrl !== 1'b1 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL prio_second got %b %0d/%h want 1 %0d/%h", interrupt_ctrl, active_id, interrupt_handling_addr, e.id, e.addr);
        end
        take_ack = 1'b1; irq_in[5] = 1'b0;
        @(negedge clk);
        take_ack = 1'b0; mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        irq_in[4] = 1'b1;
        exp_q.push_back('{id: 3'd4, addr: 32'h110});
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat < 0 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL repend_first got %0d/%h want %0d/%h (lat %0d)", active_id, interrupt_handling_addr, e.id, e.addr, lat);
        end
        irq_in[4] = 1'b0;
        @(negedge clk);
        irq_in[4] = 1'b1;
        exp_q.push_back('{id: 3'd4, addr: 32'h110});
        @(negedge clk);
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;
        checks++;
        if ({in_service, pending[4]} !== 2'b11) begin
            errors++; $display("FAIL repend_kept got %b want 11", {in_service, pending[4]});
        end
        idle_cycles(1);
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat != 1 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL repend_second got %0d/%h lat %0d want %0d/%h lat 1", active_id, interrupt_handling_addr, lat, e.id, e.addr);
        end
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;
        checks++;
        if (pending[4] !== 1'b0) begin
            errors++; $display("FAIL repend_clear got %b want 0", pending[4]);
        end
        mret = 1'b1;
        @(negedge clk);
        mret = 1'b0; irq_in[4] = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_withdraw();
        int   lat;
        exp_t e;
        irq_in[6] = 1'b1;
        exp_q.push_back('{id: 3'd6, addr: 32'h118});
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat < 0 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL withdraw_req got %0d/%h want %0d/%h (lat %0d)", active_id, interrupt_handling_addr, e.id, e.addr, lat);
        end
        en_we = 1'b1; en_wdata = 8'h00;
        @(negedge clk);
        en_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({interrupt_ctrl, pending[6]} !== 2'b01) begin
            errors++; $display("FAIL withdraw_idle got %b want 01", {interrupt_ctrl, pending[6]});
        end
        en_we = 1'b1; en_wdata = 8'hFF;
        exp_q.push_back('{id: 3'd6, addr: 32'h118});
        @(negedge clk);
        en_we = 1'b0;
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat < 0 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL withdraw_rereq got %0d/%h want %0d/%h (lat %0d)", active_id, interrupt_handling_addr, e.id, e.addr, lat);
        end
        take_ack = 1'b1; irq_in[6] = 1'b0;
        @(negedge clk);
        take_ack = 1'b0; mret = 1'b1;
        @(negedge clk);
        mret = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_masking();
        int   lat;
        exp_t e;
        global_en = 1'b0; irq_in = 8'hFF;
        idle_cycles(4);
        checks++;
        if ({interrupt_ctrl, pending} !== {1'b0, 8'hFF}) begin
            errors++; $display("FAIL mask_hold got %b/%h want 0/ff", interrupt_ctrl, pending);
        end
        global_en = 1'b1;
        exp_q.push_back('{id: 3'd0, addr: 32'h100});
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat < 0 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL mask_release got %0d/%h want %0d/%h (lat %0d)", active_id, interrupt_handling_addr, e.id, e.addr, lat);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        exp_t e;
        reset_dut();
        en_we = 1'b1; en_wdata = 8'h80; global_en = 1'b1;
        @(negedge clk);
        en_we = 1'b0; irq_in[7] = 1'b1;
        exp_q.push_back('{id: 3'd7, addr: 32'h11C});
        wait_req(lat);
        checks++;
        e = exp_q.pop_front();
        if (lat < 0 || {active_id, interrupt_handling_addr} !== {e.id, e.addr}) begin
            errors++; $display("FAIL rstmid_req got %0d/%h want %0d/%h (lat %0d)", active_id, interrupt_handling_addr, e.id, e.addr, lat);
        end
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;
        checks++;
        if (in_service !== 1'b1) begin
            errors++; $display("FAIL rstmid_active got %b want 1", in_service);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({interrupt_ctrl, in_service, active_id, interrupt_handling_addr, pending} !==
            {1'b0, 1'b0, 3'd0, 32'h100, 8'h00}) begin
            errors++; $display("FAIL rstmid_state got %b%b %0d/%h/%h want 00 0/100/00",
                               interrupt_ctrl, in_service, active_id, interrupt_handling_addr, pending);
        end
        rst = 1'b0;
        idle_cycles(4);
        checks++;
        if ({interrupt_ctrl, pending[7]} !== 2'b01) begin
            errors++; $display("FAIL rstmid_enable_cleared got %b want 01", {interrupt_ctrl, pending[7]});
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_back_to_back();
        test_withdraw();
        test_masking();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
